// File: rtl/fc_access_filter_pkg.sv
// ---------------------------------------------------------------------------
// fc_access_filter_pkg
// Shared types for the fuse-controller DAI access filter:
//   - fc_filter_state_e     : filter FSM states
//   - access_control_entry_t: one access-control range with its bound requestor
//   - DefaultAccessTable    : reference table for NumRanges = DefaultNumRanges
//   - addr_in_range()       : inclusive unsigned range test (lo > hi is empty)
// ---------------------------------------------------------------------------
package fc_access_filter_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FWD       = 2'd1,
        ADDR_HELD = 2'd2,
        DISCARD   = 2'd3
    } fc_filter_state_e;

    typedef struct packed {
        logic [31:0] start_addr;
        logic [31:0] end_addr;
        logic [31:0] user;
    } access_control_entry_t;

    localparam int DefaultNumRanges = 4;

    // Two populated ranges and two empty ones (start > end never matches).
    localparam access_control_entry_t DefaultAccessTable [DefaultNumRanges] = '{
        '{start_addr: 32'h0000_0000, end_addr: 32'h0000_003F, user: 32'h0000_0001},
        '{start_addr: 32'h0000_0040, end_addr: 32'h0000_07FF, user: 32'h0000_0002},
        '{start_addr: 32'h0000_0001, end_addr: 32'h0000_0000, user: 32'h0000_0000},
        '{start_addr: 32'h0000_0001, end_addr: 32'h0000_0000, user: 32'h0000_0000}
    };

    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] lo,
                                           input logic [31:0] hi);
        return (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/fc_range_match.sv
// ---------------------------------------------------------------------------
// fc_range_match
// Combinational access check: hit when any range is bound to i_user and
// contains i_addr (inclusive, unsigned; lo > hi is an empty range).
// Ports:
//   i_addr       fuse address under test
//   i_user       requestor under test
//   i_range_lo   NumRanges x 32-bit inclusive lower bounds (range 0 in LSBs)
//   i_range_hi   NumRanges x 32-bit inclusive upper bounds
//   i_range_user NumRanges x UserWidth bound requestors
//   o_hit        match result
// ---------------------------------------------------------------------------
module fc_range_match
    import fc_access_filter_pkg::*;
#(
    parameter int NumRanges = 4,
    parameter int UserWidth = 32
) (
    input  logic [31:0]                     i_addr,
    input  logic [UserWidth-1:0]            i_user,
    input  logic [NumRanges*32-1:0]         i_range_lo,
    input  logic [NumRanges*32-1:0]         i_range_hi,
    input  logic [NumRanges*UserWidth-1:0]  i_range_user,
    output logic                            o_hit
);

    always_comb begin
        o_hit = 1'b0;
        for (int i = 0; i < NumRanges; i++) begin
            if ((i_range_user[i*UserWidth +: UserWidth] == i_user) &&
                addr_in_range(i_addr, i_range_lo[i*32 +: 32], i_range_hi[i*32 +: 32])) begin
                o_hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fc_access_filter.sv
// ---------------------------------------------------------------------------
// fc_access_filter
// Sits between the AXI-to-register bridge and the fuse controller register
// file. Every write is forwarded, except a DAI command write, which is only
// forwarded when the same requestor previously wrote a DAI address that lies
// in one of that requestor's ranges and the address has not timed out.
// Dropped commands pulse discard_o and bump a saturating violation counter.
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   req_valid_i/req_ready_o       upstream write handshake
//   req_addr_i/wdata_i/user_i     upstream register offset, data, AXI user
//   fwd_valid_o/fwd_ready_i       downstream write handshake
//   fwd_addr_o/fwd_wdata_o        forwarded offset and data
//   range_lo_i/hi_i/user_i        access-control table (range 0 in LSBs)
//   discard_o                     one-cycle pulse per dropped command
//   viol_cnt_o                    saturating count of dropped commands
//   viol_user_o                   AXI user of the most recent drop
// ---------------------------------------------------------------------------
module fc_access_filter
    import fc_access_filter_pkg::*;
#(
    parameter int                   NumRanges     = 4,
    parameter int                   AddrWidth     = 32,
    parameter int                   UserWidth     = 32,
    parameter logic [AddrWidth-1:0] DaiAddrReg    = AddrWidth'(32'h0000_0060),
    parameter logic [AddrWidth-1:0] DaiCmdReg     = AddrWidth'(32'h0000_0064),
    parameter int                   TimeoutCycles = 256,
    parameter int                   ViolCntWidth  = 8
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            req_valid_i,
    output logic                            req_ready_o,
    input  logic [AddrWidth-1:0]            req_addr_i,
    input  logic [31:0]                     req_wdata_i,
    input  logic [UserWidth-1:0]            req_user_i,
    output logic                            fwd_valid_o,
    input  logic                            fwd_ready_i,
    output logic [AddrWidth-1:0]            fwd_addr_o,
    output logic [31:0]                     fwd_wdata_o,
    input  logic [NumRanges*32-1:0]         range_lo_i,
    input  logic [NumRanges*32-1:0]         range_hi_i,
    input  logic [NumRanges*UserWidth-1:0]  range_user_i,
    output logic                            discard_o,
    output logic [ViolCntWidth-1:0]         viol_cnt_o,
    output logic [UserWidth-1:0]            viol_user_o
);

    localparam int                TmoW    = $clog2(TimeoutCycles);
    localparam logic [TmoW-1:0]   TmoLoad = TmoW'(TimeoutCycles - 1);

    function automatic logic [ViolCntWidth-1:0] sat_inc(input logic [ViolCntWidth-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    fc_filter_state_e           r_state,      w_state_d;
    logic [31:0]                r_held_addr,  w_held_addr_d;
    logic [UserWidth-1:0]       r_held_user,  w_held_user_d;
    logic                       r_hold_valid, w_hold_valid_d;
    logic [TmoW-1:0]            r_tmo_cnt,    w_tmo_cnt_d;
    logic [AddrWidth-1:0]       r_fwd_addr,   w_fwd_addr_d;
    logic [31:0]                r_fwd_wdata,  w_fwd_wdata_d;
    logic [ViolCntWidth-1:0]    r_viol_cnt,   w_viol_cnt_d;
    logic [UserWidth-1:0]       r_viol_user,  w_viol_user_d;

    logic w_accept;
    logic w_is_addr;
    logic w_is_cmd;
    logic w_range_hit;
    logic w_cmd_ok;
    logic w_fwd_load;
    logic w_capture;
    logic w_drop;

    fc_range_match #(
        .NumRanges (NumRanges),
        .UserWidth (UserWidth)
    ) u_range_match (
        .i_addr       (r_held_addr),
        .i_user       (r_held_user),
        .i_range_lo   (range_lo_i),
        .i_range_hi   (range_hi_i),
        .i_range_user (range_user_i),
        .o_hit        (w_range_hit)
    );

    assign req_ready_o = (r_state == IDLE) || (r_state == ADDR_HELD);
    assign fwd_valid_o = (r_state == FWD);
    assign discard_o   = (r_state == DISCARD);
    assign fwd_addr_o  = r_fwd_addr;
    assign fwd_wdata_o = r_fwd_wdata;
    assign viol_cnt_o  = r_viol_cnt;
    assign viol_user_o = r_viol_user;

    assign w_accept  = req_valid_i && req_ready_o;
    assign w_is_addr = (req_addr_i == DaiAddrReg);
    assign w_is_cmd  = (req_addr_i == DaiCmdReg);
    // The command issuer must be the address writer, and the range check
    // is done against that writer's bindings.
    assign w_cmd_ok  = r_hold_valid && (req_user_i == r_held_user) && w_range_hit;

    always_comb begin
        w_state_d      = r_state;
        w_hold_valid_d = r_hold_valid;
        w_tmo_cnt_d    = r_tmo_cnt;
        w_fwd_load     = 1'b0;
        w_capture      = 1'b0;
        w_drop         = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_is_cmd && !r_hold_valid) begin
                        w_state_d = DISCARD;
                        w_drop    = 1'b1;
                    end else begin
                        w_state_d  = FWD;
                        w_fwd_load = 1'b1;
                        w_capture  = w_is_addr;
                    end
                end
            end
            FWD: begin
                if (fwd_ready_i) begin
                    w_state_d = r_hold_valid ? ADDR_HELD : IDLE;
                end
            end
            ADDR_HELD: begin
                // An accepted request takes priority over a timeout in the same cycle.
                if (w_accept) begin
                    if (w_is_cmd) begin
                        w_hold_valid_d = 1'b0;
                        if (w_cmd_ok) begin
                            w_state_d  = FWD;
                            w_fwd_load = 1'b1;
                        end else begin
                            w_state_d = DISCARD;
                            w_drop    = 1'b1;
                        end
                    end else begin
                        w_state_d  = FWD;
                        w_fwd_load = 1'b1;
                        w_capture  = w_is_addr;
                    end
                end else if (r_tmo_cnt == '0) begin
                    w_hold_valid_d = 1'b0;
                    w_state_d      = IDLE;
                end else begin
                    w_tmo_cnt_d = r_tmo_cnt - 1'b1;
                end
            end
            DISCARD: begin
                w_state_d = IDLE;
            end
            default: begin
                w_state_d      = IDLE;
                w_hold_valid_d = 1'b0;
            end
        endcase

        w_fwd_addr_d  = w_fwd_load ? req_addr_i  : r_fwd_addr;
        w_fwd_wdata_d = w_fwd_load ? req_wdata_i : r_fwd_wdata;

        w_held_addr_d = w_capture ? req_wdata_i : r_held_addr;
        w_held_user_d = w_capture ? req_user_i  : r_held_user;
        if (w_capture) begin
            w_hold_valid_d = 1'b1;
            w_tmo_cnt_d    = TmoLoad;
        end

        // Counter and user update on entry to DISCARD, so they are already
        // current while discard_o pulses.
        w_viol_cnt_d  = w_drop ? sat_inc(r_viol_cnt) : r_viol_cnt;
        w_viol_user_d = w_drop ? req_user_i          : r_viol_user;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= IDLE;
            r_held_addr  <= '0;
            r_held_user  <= '0;
            r_hold_valid <= 1'b0;
            r_tmo_cnt    <= '0;
            r_fwd_addr   <= '0;
            r_fwd_wdata  <= '0;
            r_viol_cnt   <= '0;
            r_viol_user  <= '0;
        end else begin
            r_state      <= w_state_d;
            r_held_addr  <= w_held_addr_d;
            r_held_user  <= w_held_user_d;
            r_hold_valid <= w_hold_valid_d;
            r_tmo_cnt    <= w_tmo_cnt_d;
            r_fwd_addr   <= w_fwd_addr_d;
            r_fwd_wdata  <= w_fwd_wdata_d;
            r_viol_cnt   <= w_viol_cnt_d;
            r_viol_user  <= w_viol_user_d;
        end
    end

endmodule

// File: tb/tb_fc_access_filter.sv
// ---------------------------------------------------------------------------
// tb_fc_access_filter
// Directed scenarios plus randomized traffic against a transaction-level
// reference model of the access filter (TimeoutCycles = 4, 8-bit counter).
// ---------------------------------------------------------------------------
module tb_fc_access_filter;

    localparam int NR = 4;
    localparam int AW = 32;
    localparam int UW = 32;
    localparam int T  = 4;
    localparam int VW = 8;
    localparam logic [AW-1:0] A_REG = 32'h0000_0060;
    localparam logic [AW-1:0] C_REG = 32'h0000_0064;

    logic               clk = 1'b0;
    logic               rst_ni = 1'b0;
    logic               req_valid_i = 1'b0;
    logic               req_ready_o;
    logic [AW-1:0]      req_addr_i = '0;
    logic [31:0]        req_wdata_i = '0;
    logic [UW-1:0]      req_user_i = '0;
    logic               fwd_valid_o;
    logic               fwd_ready_i;
    logic [AW-1:0]      fwd_addr_o;
    logic [31:0]        fwd_wdata_o;
    logic [NR*32-1:0]   range_lo_i = '0;
    logic [NR*32-1:0]   range_hi_i = '0;
    logic [NR*UW-1:0]   range_user_i = '0;
    logic               discard_o;
    logic [VW-1:0]      viol_cnt_o;
    logic [UW-1:0]      viol_user_o;

    always #5 clk = ~clk;

    fc_access_filter #(
        .NumRanges     (NR),
        .AddrWidth     (AW),
        .UserWidth     (UW),
        .DaiAddrReg    (A_REG),
        .DaiCmdReg     (C_REG),
        .TimeoutCycles (T),
        .ViolCntWidth  (VW)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .req_user_i   (req_user_i),
        .fwd_valid_o  (fwd_valid_o),
        .fwd_ready_i  (fwd_ready_i),
        .fwd_addr_o   (fwd_addr_o),
        .fwd_wdata_o  (fwd_wdata_o),
        .range_lo_i   (range_lo_i),
        .range_hi_i   (range_hi_i),
        .range_user_i (range_user_i),
        .discard_o    (discard_o),
        .viol_cnt_o   (viol_cnt_o),
        .viol_user_o  (viol_user_o)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Access table as seen by the model.
    logic [31:0]   rlo   [NR];
    logic [31:0]   rhi   [NR];
    logic [UW-1:0] ruser [NR];

    function automatic bit model_hit(input logic [31:0] a, input logic [UW-1:0] u);
        for (int i = 0; i < NR; i++)
            if (ruser[i] == u && a >= rlo[i] && a <= rhi[i]) return 1'b1;
        return 1'b0;
    endfunction

    // Reference model: at most one item outstanding (a downstream beat or a
    // drop notification); a held address survives T idle waiting cycles.
    int            m_pend = 0;     // 0 nothing, 1 beat owed downstream, 2 drop
    logic [AW-1:0] m_paddr = '0;
    logic [31:0]   m_pdata = '0;
    bit            m_hold = 1'b0;
    logic [31:0]   m_haddr = '0;
    logic [UW-1:0] m_huser = '0;
    int            m_wait = 0;
    int            m_vcnt = 0;
    logic [UW-1:0] m_vuser = '0;

    // Monitor log of what the DUT actually did.
    logic [AW-1:0] bq_addr [$];
    logic [31:0]   bq_data [$];
    int            disc_seen = 0;

    bit rdy_low  = 1'b0;
    bit rdy_rand = 1'b0;

    initial begin
        fwd_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_low)       fwd_ready_i = 1'b0;
            else if (rdy_rand) fwd_ready_i = ($urandom_range(0, 3) != 0);
            else               fwd_ready_i = 1'b1;
        end
    end

    // Compare process: outputs are checked at every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                m_pend = 0; m_hold = 1'b0; m_wait = 0; m_vcnt = 0; m_vuser = '0;
                chk("rst_req_ready", 64'(req_ready_o), 64'(1));
                chk("rst_fwd_valid", 64'(fwd_valid_o), 64'(0));
                chk("rst_fwd_addr",  64'(fwd_addr_o),  64'(0));
                chk("rst_fwd_wdata", 64'(fwd_wdata_o), 64'(0));
                chk("rst_discard",   64'(discard_o),   64'(0));
                chk("rst_viol_cnt",  64'(viol_cnt_o),  64'(0));
                chk("rst_viol_user", 64'(viol_user_o), 64'(0));
            end else begin
                chk("req_ready", 64'(req_ready_o), 64'(m_pend == 0));
                chk("fwd_valid", 64'(fwd_valid_o), 64'(m_pend == 1));
                if (m_pend == 1) begin
                    chk("fwd_addr",  64'(fwd_addr_o),  64'(m_paddr));
                    chk("fwd_wdata", 64'(fwd_wdata_o), 64'(m_pdata));
                end
                chk("discard",   64'(discard_o),   64'(m_pend == 2));
                chk("viol_cnt",  64'(viol_cnt_o),  64'((m_vcnt > 255) ? 255 : m_vcnt));
                chk("viol_user", 64'(viol_user_o), 64'(m_vuser));

                if (fwd_valid_o && fwd_ready_i) begin
                    bq_addr.push_back(fwd_addr_o);
                    bq_data.push_back(fwd_wdata_o);
                end
                if (discard_o) disc_seen++;

                case (m_pend)
                    1: if (fwd_ready_i) m_pend = 0;
                    2: m_pend = 0;
                    default: begin
                        if (req_valid_i) begin
                            if (req_addr_i == C_REG) begin
                                if (m_hold && req_user_i == m_huser && model_hit(m_haddr, m_huser)) begin
                                    m_pend = 1; m_paddr = req_addr_i; m_pdata = req_wdata_i;
                                end else begin
                                    m_pend = 2; m_vcnt++; m_vuser = req_user_i;
                                end
                                m_hold = 1'b0;
                            end else begin
                                m_pend = 1; m_paddr = req_addr_i; m_pdata = req_wdata_i;
                                if (req_addr_i == A_REG) begin
                                    m_hold = 1'b1; m_haddr = req_wdata_i; m_huser = req_user_i; m_wait = 0;
                                end
                            end
                        end else if (m_hold) begin
                            if (m_wait == T - 1) m_hold = 1'b0;
                            else                 m_wait++;
                        end
                    end
                endcase
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        idle(2);
        rst_ni = 1'b1;
        idle(1);
    endtask

    task automatic set_range(input int i, input logic [31:0] lo, input logic [31:0] hi, input logic [UW-1:0] u);
        rlo[i] = lo; rhi[i] = hi; ruser[i] = u;
        range_lo_i[i*32 +: 32]   = lo;
        range_hi_i[i*32 +: 32]   = hi;
        range_user_i[i*UW +: UW] = u;
    endtask

    task automatic base_ranges();
        set_range(0, 32'h0, 32'hFFFF, 32'hA);
        for (int i = 1; i < NR; i++) set_range(i, 32'h1, 32'h0, 32'h0);
    endtask

    task automatic send(input logic [AW-1:0] a, input logic [31:0] d, input logic [UW-1:0] u);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        req_valid_i = 1'b1; req_addr_i = a; req_wdata_i = d; req_user_i = u;
        while (!acc && n < 64) begin
            @(negedge clk);
            acc = req_ready_o && rst_ni;
            @(posedge clk);
            #1;
            n++;
        end
        req_valid_i = 1'b0;
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL req_accept: no handshake within %0d cycles", n);
        end
    endtask

    logic [UW-1:0] users [3] = '{32'hA, 32'hB, 32'hC};

    initial begin
        int nb;
        int nd;
        logic [31:0]   lo;
        logic [31:0]   hi;
        logic [UW-1:0] u;
        logic [UW-1:0] last_u;
        int kind;

        base_ranges();
        idle(3);
        rst_ni = 1'b1;
        idle(1);

        // Matching address + command by the same requestor: both forwarded.
        do_reset();
        nb = bq_addr.size(); nd = disc_seen;
        send(A_REG, 32'h100, 32'hA);
        send(C_REG, 32'h2, 32'hA);
        idle(3);
        chk("s1_beats", 64'(bq_addr.size() - nb), 64'(2));
        chk("s1_beat0_addr", 64'(bq_addr[nb]), 64'(32'h60));
        chk("s1_beat0_data", 64'(bq_data[nb]), 64'(32'h100));
        chk("s1_beat1_addr", 64'(bq_addr[nb+1]), 64'(32'h64));
        chk("s1_beat1_data", 64'(bq_data[nb+1]), 64'(32'h2));
        chk("s1_no_discard", 64'(disc_seen - nd), 64'(0));
        chk("s1_viol_cnt", 64'(viol_cnt_o), 64'(0));

        // Command from a different requestor: dropped.
        do_reset();
        nb = bq_addr.size(); nd = disc_seen;
        send(A_REG, 32'h100, 32'hA);
        send(C_REG, 32'h2, 32'hB);
        idle(3);
        chk("s2_beats", 64'(bq_addr.size() - nb), 64'(1));
        chk("s2_discards", 64'(disc_seen - nd), 64'(1));
        chk("s2_viol_cnt", 64'(viol_cnt_o), 64'(1));
        chk("s2_viol_user", 64'(viol_user_o), 64'(32'hB));

        // Address outside every range: dropped; in-range address then passes.
        do_reset();
        nb = bq_addr.size();
        send(A_REG, 32'h20000, 32'hA);
        send(C_REG, 32'h3, 32'hA);
        idle(2);
        chk("s3_viol_cnt_a", 64'(viol_cnt_o), 64'(1));
        send(A_REG, 32'h200, 32'hA);
        send(C_REG, 32'h4, 32'hA);
        idle(3);
        chk("s3_viol_cnt_b", 64'(viol_cnt_o), 64'(1));
        chk("s3_beats", 64'(bq_addr.size() - nb), 64'(3));
        chk("s3_last_cmd", 64'(bq_data[bq_data.size()-1]), 64'(32'h4));

        // Timeout: command one cycle past the hold window is dropped,
        // command in the last valid cycle is forwarded.
        do_reset();
        send(A_REG, 32'h100, 32'hA);
        idle(5);
        send(C_REG, 32'h5, 32'hA);
        idle(2);
        chk("s4_late_viol", 64'(viol_cnt_o), 64'(1));
        nb = bq_addr.size();
        send(A_REG, 32'h100, 32'hA);
        idle(4);
        send(C_REG, 32'h6, 32'hA);
        idle(3);
        chk("s4_edge_viol", 64'(viol_cnt_o), 64'(1));
        chk("s4_edge_beats", 64'(bq_addr.size() - nb), 64'(2));
        chk("s4_edge_cmd", 64'(bq_data[bq_data.size()-1]), 64'(32'h6));

        // Downstream stall: forward stays presented, upstream blocked.
        do_reset();
        rdy_low = 1'b1;
        idle(1);
        send(32'h10, 32'h55, 32'hA);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("stall_req_ready", 64'(req_ready_o), 64'(0));
            chk("stall_fwd_valid", 64'(fwd_valid_o), 64'(1));
            chk("stall_fwd_addr",  64'(fwd_addr_o),  64'(32'h10));
            chk("stall_fwd_wdata", 64'(fwd_wdata_o), 64'(32'h55));
            @(posedge clk);
            #1;
        end
        rdy_low = 1'b0;
        idle(3);
        chk("stall_released", 64'(req_ready_o), 64'(1));

        // Violation counter saturation.
        do_reset();
        for (int k = 0; k < 300; k++) send(C_REG, $urandom, 32'hC);
        idle(2);
        chk("sat_viol_cnt", 64'(viol_cnt_o), 64'(8'hFF));
        chk("sat_viol_user", 64'(viol_user_o), 64'(32'hC));

        // Reset while an address is held: the hold is lost.
        do_reset();
        send(A_REG, 32'h100, 32'hA);
        idle(2);
        rst_ni = 1'b0;
        @(negedge clk);
        chk("mid_rst_ready", 64'(req_ready_o), 64'(1));
        chk("mid_rst_fwd_valid", 64'(fwd_valid_o), 64'(0));
        chk("mid_rst_fwd_addr", 64'(fwd_addr_o), 64'(0));
        idle(1);
        rst_ni = 1'b1;
        idle(1);
        nd = disc_seen;
        send(C_REG, 32'h7, 32'hA);
        idle(3);
        chk("post_rst_discards", 64'(disc_seen - nd), 64'(1));
        chk("post_rst_viol_cnt", 64'(viol_cnt_o), 64'(1));

        // Randomized traffic.
        rdy_rand = 1'b1;
        last_u = 32'hA;
        for (int n = 0; n < 500; n++) begin
            if (n % 50 == 0) begin
                for (int i = 0; i < NR; i++) begin
                    lo = 32'($urandom_range(1, 'h300));
                    if ($urandom_range(0, 4) == 0) hi = lo - 32'd1;
                    else                           hi = lo + 32'($urandom_range(0, 'h200));
                    set_range(i, lo, hi, users[$urandom_range(0, 2)]);
                end
            end
            if (n % 97 == 96) do_reset();
            kind = int'($urandom_range(0, 9));
            u = users[$urandom_range(0, 2)];
            if (kind < 4) begin
                send(A_REG, 32'($urandom_range(0, 'h600)), u);
                last_u = u;
            end else if (kind < 8) begin
                send(C_REG, $urandom, ($urandom_range(0, 9) < 7) ? last_u : u);
            end else begin
                send(AW'($urandom_range(0, 63)) << 2, $urandom, u);
            end
            idle(int'($urandom_range(0, 6)));
        end
        rdy_rand = 1'b0;
        idle(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
